// File: rtl/camera_capture_pkg.sv
// camera_capture_pkg
// Shared types and default constants for the camera capture front end.
//   cap_state_t  : capture FSM states
//   beat_flags_t : packet framing flags carried alongside each pixel beat
package camera_capture_pkg;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_COORD_W    = 12;
    localparam int DEF_SKIP_W     = 4;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int STAT_CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SKIP    = 3'd2,
        DONE    = 3'd3,
        DROP    = 3'd4
    } cap_state_t;

    // Framing part of a beat; the full beat {data, sop, eop} is built in the
    // top where the data width parameter is known.
    typedef struct packed {
        logic sop;
        logic eop;
    } beat_flags_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO with a registered head stage.
//   clk, rst_n      : clock, asynchronous active-low reset
//   srst            : synchronous flush
//   wr_en, wr_data  : write port (ignored when storage is full)
//   rd_en           : consume head beat when rd_valid is high
//   rd_data, rd_valid : registered head of queue
//   count           : total entries held, including the head register
// A written entry reaches the head register one cycle after the write.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      mem_cnt_r;
    logic [AW:0]      mem_cnt_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             wr_ok_s;
    logic             pop_s;
    logic             load_s;

    // Handshake decode and storage occupancy update.
    always_comb begin
        wr_ok_s = wr_en && (mem_cnt_r != (AW+1)'(DEPTH));
        pop_s   = out_valid_r && rd_en;
        load_s  = (!out_valid_r || pop_s) && (mem_cnt_r != '0);
        case ({wr_ok_s, load_s})
            2'b10:   mem_cnt_s = mem_cnt_r + (AW+1)'(1);
            2'b01:   mem_cnt_s = mem_cnt_r - (AW+1)'(1);
            default: mem_cnt_s = mem_cnt_r;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            mem_cnt_r   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (srst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            mem_cnt_r   <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            mem_cnt_r <= mem_cnt_s;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (load_s) begin
                rd_ptr_r    <= rd_ptr_r + AW'(1);
                out_valid_r <= 1'b1;
                out_data_r  <= mem_r[rd_ptr_r];
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
                out_data_r  <= '0;
            end
        end
    end

    assign rd_data  = out_data_r;
    assign rd_valid = out_valid_r;
    assign count    = mem_cnt_r + (AW+1)'(out_valid_r);

endmodule

// File: rtl/camera_stream_capture.sv
// camera_stream_capture
// Converts the sensor FVAL/LVAL/D pixel bus into an Avalon-ST video packet
// stream with crop window, frame decimation and overflow/short-frame
// terminators.
//   clk, reset_n                     : pixel clock, async active-low reset
//   cam_d, cam_fval, cam_lval        : raw sensor bus
//   cfg_enable, cfg_x0/y0/w/h, cfg_skip : capture configuration
//   st_data/valid/ready/sop/eop      : Avalon-ST source
//   stat_overflow, stat_frame_cnt, stat_clear : status and its clear
// The first LVAL of a frame is expected at least one clock after FVAL rises,
// which holds for the D8M sensor timing.
module camera_stream_capture
    import camera_capture_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int SKIP_W     = DEF_SKIP_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     cam_d,
    input  logic                  cam_fval,
    input  logic                  cam_lval,
    input  logic                  cfg_enable,
    input  logic [COORD_W-1:0]    cfg_x0,
    input  logic [COORD_W-1:0]    cfg_y0,
    input  logic [COORD_W-1:0]    cfg_w,
    input  logic [COORD_W-1:0]    cfg_h,
    input  logic [SKIP_W-1:0]     cfg_skip,
    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_sop,
    output logic                  st_eop,
    output logic                  stat_overflow,
    output logic [STAT_CNT_W-1:0] stat_frame_cnt,
    input  logic                  stat_clear
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        beat_flags_t       flags;
    } beat_t;

    logic [DATA_W-1:0]     d_r;
    logic                  fval_r, lval_r, fval_d_r, lval_d_r;
    logic [COORD_W-1:0]    x_r, y_r;
    logic [COORD_W-1:0]    sh_x0_r, sh_y0_r, sh_w_r, sh_h_r;
    logic [SKIP_W-1:0]     skip_cnt_r;
    cap_state_t            state_r, state_s;
    logic                  sop_seen_r;
    logic                  ovf_r;
    logic [STAT_CNT_W-1:0] frame_cnt_r;

    logic                  fval_rise_s, lval_fall_s;
    logic [COORD_W:0]      x_ext_s, y_ext_s, x_end_s, y_end_s;
    logic                  in_win_s, is_sop_s, is_eop_s, room_s;
    logic                  wr_en_s, set_ovf_s, start_cap_s, start_skip_s;
    beat_t                 wr_beat_s, rd_beat_s;
    logic                  rd_valid_s;
    logic [CNT_W-1:0]      fifo_cnt_s;

    // Input stage. FVAL copies reset high so that a frame already in flight
    // when reset releases cannot look like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_r      <= '0;
            fval_r   <= 1'b1;
            lval_r   <= 1'b0;
            fval_d_r <= 1'b1;
            lval_d_r <= 1'b0;
        end else begin
            d_r      <= cam_d;
            fval_r   <= cam_fval;
            lval_r   <= cam_lval;
            fval_d_r <= fval_r;
            lval_d_r <= lval_r;
        end
    end

    assign fval_rise_s = fval_r && !fval_d_r;
    assign lval_fall_s = !lval_r && lval_d_r;

    // Pixel coordinates and frame-start shadow of the crop window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r     <= '0;
            y_r     <= '0;
            sh_x0_r <= '0;
            sh_y0_r <= '0;
            sh_w_r  <= '0;
            sh_h_r  <= '0;
        end else begin
            x_r <= lval_r ? (x_r + COORD_W'(1)) : '0;
            if (fval_rise_s) begin
                y_r     <= '0;
                sh_x0_r <= cfg_x0;
                sh_y0_r <= cfg_y0;
                sh_w_r  <= cfg_w;
                sh_h_r  <= cfg_h;
            end else if (lval_fall_s) begin
                y_r <= y_r + COORD_W'(1);
            end
        end
    end

    // Window membership; one extra bit keeps x0+w from wrapping.
    always_comb begin
        x_ext_s  = {1'b0, x_r};
        y_ext_s  = {1'b0, y_r};
        x_end_s  = {1'b0, sh_x0_r} + {1'b0, sh_w_r};
        y_end_s  = {1'b0, sh_y0_r} + {1'b0, sh_h_r};
        in_win_s = fval_r && lval_r
                && (x_ext_s >= {1'b0, sh_x0_r}) && (x_ext_s < x_end_s)
                && (y_ext_s >= {1'b0, sh_y0_r}) && (y_ext_s < y_end_s);
        is_sop_s = (x_r == sh_x0_r) && (y_r == sh_y0_r);
        is_eop_s = (x_ext_s == x_end_s - (COORD_W+1)'(1))
                && (y_ext_s == y_end_s - (COORD_W+1)'(1));
        room_s   = fifo_cnt_s < CNT_W'(FIFO_DEPTH - 1);
    end

    // Capture FSM next state and FIFO write decision. A terminator is only
    // written once a SOP has gone out, so every packet stays well formed.
    always_comb begin
        state_s      = state_r;
        wr_en_s      = 1'b0;
        wr_beat_s    = '0;
        set_ovf_s    = 1'b0;
        start_cap_s  = 1'b0;
        start_skip_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fval_rise_s) begin
                    if (cfg_enable && (skip_cnt_r == '0)) begin
                        state_s     = CAPTURE;
                        start_cap_s = 1'b1;
                    end else begin
                        state_s      = SKIP;
                        start_skip_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (!fval_r) begin
                    state_s = IDLE;
                    if (sop_seen_r) begin
                        wr_en_s             = 1'b1;
                        wr_beat_s.flags.eop = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end else if (in_win_s) begin
                    if (room_s) begin
                        wr_en_s             = 1'b1;
                        wr_beat_s.data      = d_r;
                        wr_beat_s.flags.sop = is_sop_s;
                        wr_beat_s.flags.eop = is_eop_s;
                        state_s             = is_eop_s ? DONE : CAPTURE;
                    end else begin
                        set_ovf_s = 1'b1;
                        state_s   = DROP;
                        if (sop_seen_r) begin
                            wr_en_s             = 1'b1;
                            wr_beat_s.flags.eop = 1'b1;
                        end else begin
                            wr_en_s = 1'b0;
                        end
                    end
                end else begin
                    state_s = CAPTURE;
                end
            end
            SKIP, DONE, DROP: begin
                if (!fval_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, per-frame SOP tracking and decimation counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            sop_seen_r <= 1'b0;
            skip_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (start_cap_s) begin
                sop_seen_r <= 1'b0;
                skip_cnt_r <= cfg_skip;
            end else begin
                if (wr_en_s && wr_beat_s.flags.sop) begin
                    sop_seen_r <= 1'b1;
                end
                if (start_skip_s && (skip_cnt_r != '0)) begin
                    skip_cnt_r <= skip_cnt_r - SKIP_W'(1);
                end
            end
        end
    end

    // Status registers; a clear beats a same-cycle set or increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r       <= 1'b0;
            frame_cnt_r <= '0;
        end else if (stat_clear) begin
            ovf_r       <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            if (set_ovf_s) begin
                ovf_r <= 1'b1;
            end
            if (wr_en_s && wr_beat_s.flags.sop) begin
                frame_cnt_r <= frame_cnt_r + STAT_CNT_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .srst     (1'b0),
        .wr_en    (wr_en_s),
        .wr_data  (wr_beat_s),
        .rd_en    (st_ready),
        .rd_data  (rd_beat_s),
        .rd_valid (rd_valid_s),
        .count    (fifo_cnt_s)
    );

    assign st_data        = rd_beat_s.data;
    assign st_sop         = rd_beat_s.flags.sop;
    assign st_eop         = rd_beat_s.flags.eop;
    assign st_valid       = rd_valid_s;
    assign stat_overflow  = ovf_r;
    assign stat_frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_camera_stream_capture.sv
// tb_camera_stream_capture
// Directed bench for camera_stream_capture: frames are generated as an
// 8-pixel-wide raster with pixel value y*16+x, beats are collected from the
// stream port and compared against hand-written expectations.
module tb_camera_stream_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] cam_d;
    logic        cam_fval, cam_lval;
    logic        cfg_enable;
    logic [11:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
    logic [3:0]  cfg_skip;
    logic [11:0] st_data;
    logic        st_valid, st_ready, st_sop, st_eop;
    logic        stat_overflow;
    logic [15:0] stat_frame_cnt;
    logic        stat_clear;

    int checks = 0;
    int errors = 0;

    logic [13:0] beats_q [$];
    logic        snap_valid, snap_sop, snap_eop, snap_ovf;
    logic [11:0] snap_data;
    logic [15:0] snap_cnt;

    always #5 clk = ~clk;

    camera_stream_capture dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cam_d          (cam_d),
        .cam_fval       (cam_fval),
        .cam_lval       (cam_lval),
        .cfg_enable     (cfg_enable),
        .cfg_x0         (cfg_x0),
        .cfg_y0         (cfg_y0),
        .cfg_w          (cfg_w),
        .cfg_h          (cfg_h),
        .cfg_skip       (cfg_skip),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .stat_overflow  (stat_overflow),
        .stat_frame_cnt (stat_frame_cnt),
        .stat_clear     (stat_clear)
    );

    // Beat collector: outputs are stable at the falling edge before the
    // rising edge on which the transfer happens.
    always @(negedge clk) begin
        if (st_valid && st_ready) beats_q.push_back({st_sop, st_eop, st_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic set_window(input int x0, input int y0, input int w, input int h);
        cfg_x0 = 12'(x0);
        cfg_y0 = 12'(y0);
        cfg_w  = 12'(w);
        cfg_h  = 12'(h);
    endtask

    task automatic pulse_clear();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    // One frame of fw x fh pixels. stop_pix drops FVAL before that raster
    // index, chg_pix rewrites cfg_x0, rst_pix pulses reset for one cycle.
    task automatic run_frame(input int fw, input int fh, input int stop_pix,
                             input int chg_pix, input logic [11:0] chg_x0,
                             input int rst_pix);
        int pix;
        bit stopped;
        pix = 0;
        stopped = 1'b0;
        cam_fval = 1'b0; cam_lval = 1'b0; cam_d = 12'd0;
        repeat (3) tick();
        cam_fval = 1'b1;
        tick();
        for (int y = 0; y < fh && !stopped; y++) begin
            for (int x = 0; x < fw && !stopped; x++) begin
                if (pix == stop_pix) begin
                    stopped = 1'b1;
                end else begin
                    if (pix == chg_pix) cfg_x0 = chg_x0;
                    cam_lval = 1'b1;
                    cam_d = 12'(y * 16 + x);
                    if (pix == rst_pix) begin
                        reset_n = 1'b0;
                        #1;
                        snap_valid = st_valid; snap_sop = st_sop; snap_eop = st_eop;
                        snap_data = st_data; snap_cnt = stat_frame_cnt; snap_ovf = stat_overflow;
                        beats_q.delete();
                        tick();
                        reset_n = 1'b1;
                    end else begin
                        tick();
                    end
                    pix++;
                end
            end
            cam_lval = 1'b0;
            tick();
            tick();
        end
        cam_fval = 1'b0; cam_lval = 1'b0; cam_d = 12'd0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cam_d = 12'd0; cam_fval = 1'b0; cam_lval = 1'b0;
        cfg_enable = 1'b1; cfg_skip = 4'd0; set_window(0, 0, 0, 0);
        st_ready = 1'b1; stat_clear = 1'b0;
        repeat (3) tick();
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", st_valid); end
        checks++; if (st_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b want 0", st_sop); end
        checks++; if (st_eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b want 0", st_eop); end
        checks++; if (st_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", st_data); end
        checks++; if (stat_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", stat_overflow); end
        checks++; if (stat_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stat_frame_cnt); end
        reset_n = 1'b1;
        drain(3);
        checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", st_valid); end
    endtask

    task automatic test_basic_window();
        logic [11:0] exp_d [8];
        logic [13:0] b;
        exp_d = '{12'h012, 12'h013, 12'h014, 12'h015, 12'h022, 12'h023, 12'h024, 12'h025};
        set_window(2, 1, 4, 2); cfg_skip = 4'd0; st_ready = 1'b1;
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(30);
        checks++; if (beats_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", beats_q.size()); end
        for (int i = 0; i < 8 && i < int'(beats_q.size()); i++) begin
            b = beats_q[i];
            checks++;
            if (b !== {i == 0, i == 7, exp_d[i]}) begin
                errors++; $display("FAIL basic_beat%0d: got %h want %h", i, b, {i == 0, i == 7, exp_d[i]});
            end
        end
        checks++; if (stat_frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", stat_frame_cnt); end
        checks++; if (stat_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", stat_overflow); end
    endtask

    task automatic test_skip();
        logic [13:0] b;
        pulse_clear();
        set_window(2, 1, 4, 2); cfg_skip = 4'd2; st_ready = 1'b1;
        beats_q.delete();
        // frames 1 and 4 captured; 5 and 6 skipped to bring the counter back to 0
        repeat (6) run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(30);
        cfg_skip = 4'd0;
        checks++; if (beats_q.size() != 16) begin errors++; $display("FAIL skip_count: got %0d want 16", beats_q.size()); end
        if (beats_q.size() == 16) begin
            b = beats_q[0];
            checks++; if (b !== 14'h2012) begin errors++; $display("FAIL skip_first: got %h want 2012", b); end
            b = beats_q[8];
            checks++; if (b !== 14'h2012) begin errors++; $display("FAIL skip_second_sop: got %h want 2012", b); end
            b = beats_q[15];
            checks++; if (b !== 14'h1025) begin errors++; $display("FAIL skip_last: got %h want 1025", b); end
        end
        checks++; if (stat_frame_cnt !== 16'd2) begin errors++; $display("FAIL skip_frame_cnt: got %0d want 2", stat_frame_cnt); end
    endtask

    task automatic test_overflow();
        logic [13:0] b;
        logic [13:0] e;
        pulse_clear();
        set_window(0, 0, 8, 4); st_ready = 1'b0;
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        checks++; if (stat_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", stat_overflow); end
        checks++; if (st_valid !== 1'b1 || st_sop !== 1'b1) begin errors++; $display("FAIL ovf_head: got valid %b sop %b want 1 1", st_valid, st_sop); end
        st_ready = 1'b1;
        drain(30);
        checks++; if (beats_q.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d want 16", beats_q.size()); end
        for (int i = 0; i < 16 && i < int'(beats_q.size()); i++) begin
            b = beats_q[i];
            e = (i == 15) ? 14'h1000 : {i == 0, 1'b0, 12'((i / 8) * 16 + (i % 8))};
            checks++; if (b !== e) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, b, e); end
        end
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(40);
        checks++; if (beats_q.size() != 32) begin errors++; $display("FAIL clean_count: got %0d want 32", beats_q.size()); end
        if (beats_q.size() == 32) begin
            b = beats_q[0];
            checks++; if (b !== 14'h2000) begin errors++; $display("FAIL clean_first: got %h want 2000", b); end
            b = beats_q[31];
            checks++; if (b !== 14'h1037) begin errors++; $display("FAIL clean_last: got %h want 1037", b); end
        end
        checks++; if (stat_frame_cnt !== 16'd2) begin errors++; $display("FAIL clean_frame_cnt: got %0d want 2", stat_frame_cnt); end
    endtask

    task automatic test_short_frame();
        logic [13:0] exp_b [4];
        logic [13:0] b;
        exp_b = '{14'h2012, 14'h0013, 14'h0014, 14'h1000};
        set_window(2, 1, 4, 2); st_ready = 1'b1;
        beats_q.delete();
        run_frame(8, 4, 13, -1, 12'd0, -1);
        drain(20);
        checks++; if (beats_q.size() != 4) begin errors++; $display("FAIL short_count: got %0d want 4", beats_q.size()); end
        for (int i = 0; i < 4 && i < int'(beats_q.size()); i++) begin
            b = beats_q[i];
            checks++; if (b !== exp_b[i]) begin errors++; $display("FAIL short_beat%0d: got %h want %h", i, b, exp_b[i]); end
        end
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(30);
        checks++; if (beats_q.size() != 8) begin errors++; $display("FAIL short_next_count: got %0d want 8", beats_q.size()); end
        if (beats_q.size() > 0) begin
            b = beats_q[0];
            checks++; if (b !== 14'h2012) begin errors++; $display("FAIL short_next_sop: got %h want 2012", b); end
        end
    endtask

    task automatic test_cfg_change();
        logic [11:0] exp_new [8];
        logic [13:0] b;
        exp_new = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h020, 12'h021, 12'h022, 12'h023};
        set_window(2, 1, 4, 2); st_ready = 1'b1;
        beats_q.delete();
        run_frame(8, 4, -1, 3, 12'd0, -1);
        drain(30);
        checks++; if (beats_q.size() != 8) begin errors++; $display("FAIL cfg_old_count: got %0d want 8", beats_q.size()); end
        if (beats_q.size() == 8) begin
            b = beats_q[0];
            checks++; if (b !== 14'h2012) begin errors++; $display("FAIL cfg_old_first: got %h want 2012", b); end
            b = beats_q[7];
            checks++; if (b !== 14'h1025) begin errors++; $display("FAIL cfg_old_last: got %h want 1025", b); end
        end
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(30);
        checks++; if (beats_q.size() != 8) begin errors++; $display("FAIL cfg_new_count: got %0d want 8", beats_q.size()); end
        for (int i = 0; i < 8 && i < int'(beats_q.size()); i++) begin
            b = beats_q[i];
            checks++;
            if (b !== {i == 0, i == 7, exp_new[i]}) begin
                errors++; $display("FAIL cfg_new_beat%0d: got %h want %h", i, b, {i == 0, i == 7, exp_new[i]});
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [13:0] b;
        set_window(2, 1, 4, 2); st_ready = 1'b1;
        run_frame(8, 4, -1, -1, 12'd0, 12);
        drain(20);
        checks++; if (snap_valid !== 1'b0 || snap_sop !== 1'b0 || snap_eop !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got v%b s%b e%b want 0 0 0", snap_valid, snap_sop, snap_eop); end
        checks++; if (snap_data !== 12'h000) begin errors++; $display("FAIL rst_data: got %h want 000", snap_data); end
        checks++; if (snap_cnt !== 16'd0 || snap_ovf !== 1'b0) begin
            errors++; $display("FAIL rst_stats: got cnt %0d ovf %b want 0 0", snap_cnt, snap_ovf); end
        checks++; if (beats_q.size() != 0) begin errors++; $display("FAIL rst_remainder: got %0d beats want 0", beats_q.size()); end
        beats_q.delete();
        run_frame(8, 4, -1, -1, 12'd0, -1);
        drain(30);
        checks++; if (beats_q.size() != 8) begin errors++; $display("FAIL rst_next_count: got %0d want 8", beats_q.size()); end
        if (beats_q.size() > 0) begin
            b = beats_q[0];
            checks++; if (b !== 14'h2012) begin errors++; $display("FAIL rst_next_sop: got %h want 2012", b); end
        end
        checks++; if (stat_frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_next_cnt: got %0d want 1", stat_frame_cnt); end
        set_window(0, 0, 8, 4); st_ready = 1'b0;
        run_frame(8, 4, -1, -1, 12'd0, -1);
        checks++; if (stat_overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b want 1", stat_overflow); end
        pulse_clear();
        checks++; if (stat_overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", stat_overflow); end
        checks++; if (stat_frame_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", stat_frame_cnt); end
        st_ready = 1'b1;
        drain(30);
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_skip();
        test_overflow();
        test_short_frame();
        test_cfg_change();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
